music_note_sequencer: RTL and testbench

Controller that sequences the music tone generator from a song ROM, stepping one note at a time in units of VGA frames. It sits between the VGA timing block (source of `frame_tick`) and the square-wave tone generator (consumer of `note_period`/`note_gate`). It reads the external combinational song ROM through `rom_addr`/`rom_data`. It also handles start, stop and looping, and converts pitch codes into half-period counts.

---
 rtl/music_note_sequencer.sv | 258 +++++++++++++++++++++++++
 tb/tb_music_note_sequencer.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/music_note_sequencer.sv
// -----------------------------------------------------------------------------
// music_note_sequencer
//
// Steps through an external combinational song ROM one note at a time and
// drives the square-wave tone generator. Note lengths are counted in VGA
// frames (frame_tick). Pitch codes are translated into tone half-periods in
// clock cycles (25.175 MHz system clock).
//
// ROM entry format: {pitch[6:3], dur[2:0]}
//   pitch 0, 13, 14 : rest (period 0, gate low)
//   pitch 1..12     : C4..B4
//   pitch 15        : END marker (finish, or wrap to step 0 when loop=1)
//   note length     : (dur+1) * U frames; the last GAP_FRAMES frames are silent
//
// Configuration macro: MUSIC_SEQ_TEMPO_EN
//   defined     : tempo selects U (00->4, 01->6, 10->8, 11->12), sampled at LOAD
//   not defined : tempo is ignored and U is fixed at 8
//
// Ports:
//   clk          in   system clock
//   rst_n        in   asynchronous active-low reset
//   frame_tick   in   one-cycle pulse per VGA frame
//   start        in   pulse, (re)start the song at step 0
//   stop         in   pulse, abort to idle (wins over start)
//   loop         in   level, wrap to step 0 at end of song
//   tempo        in   frames per duration unit select
//   rom_addr     out  current song step
//   rom_data     in   ROM word for rom_addr, same cycle
//   note_period  out  tone half-period in clocks, 0 = silent
//   note_gate    out  tone enable
//   note_strobe  out  one-cycle pulse when a note is loaded
//   busy         out  high while loading or playing
//   done         out  high once the song has finished (loop=0)
// -----------------------------------------------------------------------------
module music_note_sequencer #(
    parameter int SONG_LEN   = 32,
    parameter int GAP_FRAMES = 2,
    parameter int PERIOD_W   = 16,
    localparam int AW        = $clog2(SONG_LEN)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                frame_tick,
    input  logic                start,
    input  logic                stop,
    input  logic                loop,
    input  logic [1:0]          tempo,
    output logic [AW-1:0]       rom_addr,
    input  logic [6:0]          rom_data,
    output logic [PERIOD_W-1:0] note_period,
    output logic                note_gate,
    output logic                note_strobe,
    output logic                busy,
    output logic                done
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_PLAY = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam logic [AW-1:0] LAST_ADDR = AW'(SONG_LEN - 1);
    localparam logic [3:0]    PITCH_END = 4'd15;
    // Gate drops when the frame counter steps from GAP_TRIP down to GAP_FRAMES.
    // A note no longer than the gap never passes through that value, so its
    // gate stays as loaded for the whole note without any extra bookkeeping.
    localparam logic [6:0]    GAP_TRIP  = 7'(GAP_FRAMES + 1);
    localparam bit            GAP_EN    = (GAP_FRAMES != 0);

    // Half-period = round(25_175_000 / (2 * f)) for the C4..B4 octave.
    function automatic logic [15:0] pitch_half_period(input logic [3:0] pitch);
        logic [15:0] hp;
        case (pitch)
            4'd1:    hp = 16'd48113;  // C4
            4'd2:    hp = 16'd45412;  // C#4
            4'd3:    hp = 16'd42864;  // D4
            4'd4:    hp = 16'd40458;  // D#4
            4'd5:    hp = 16'd38187;  // E4
            4'd6:    hp = 16'd36044;  // F4
            4'd7:    hp = 16'd34021;  // F#4
            4'd8:    hp = 16'd32111;  // G4
            4'd9:    hp = 16'd30309;  // G#4
            4'd10:   hp = 16'd28608;  // A4
            4'd11:   hp = 16'd27002;  // A#4
            4'd12:   hp = 16'd25487;  // B4
            default: hp = 16'd0;      // rests and END are silent
        endcase
        return hp;
    endfunction

    function automatic logic pitch_is_tone(input logic [3:0] pitch);
        return (pitch >= 4'd1) && (pitch <= 4'd12);
    endfunction

    state_t                state_r,  state_s;
    logic [AW-1:0]         addr_r,   addr_s;
    logic [6:0]            cnt_r,    cnt_s;
    logic [PERIOD_W-1:0]   period_r, period_s;
    logic                  gate_r,   gate_s;
    logic                  strobe_r, strobe_s;
    logic                  busy_r,   busy_s;
    logic                  done_r,   done_s;

    logic [3:0]            pitch_s;
    logic [2:0]            dur_s;
    logic [6:0]            unit_s;
    logic [6:0]            note_len_s;

    assign pitch_s = rom_data[6:3];
    assign dur_s   = rom_data[2:0];

`ifdef MUSIC_SEQ_TEMPO_EN
    // Frames per duration unit from the tempo select
    always_comb begin
        case (tempo)
            2'b00:   unit_s = 7'd4;
            2'b01:   unit_s = 7'd6;
            2'b10:   unit_s = 7'd8;
            2'b11:   unit_s = 7'd12;
            default: unit_s = 7'd8;
        endcase
    end
`else
    logic tempo_unused_s;
    assign tempo_unused_s = ^tempo;
    assign unit_s         = 7'd8;
`endif

    // Longest note is 8 units of 12 frames = 96, which fits the 7-bit counter.
    assign note_len_s = 7'(({4'd0, dur_s} + 7'd1) * unit_s);

    // Next-state and next-output logic of the sequencing FSM
    always_comb begin
        state_s  = state_r;
        addr_s   = addr_r;
        cnt_s    = cnt_r;
        period_s = period_r;
        gate_s   = gate_r;
        strobe_s = 1'b0;

        if (stop) begin
            state_s  = ST_IDLE;
            addr_s   = '0;
            cnt_s    = 7'd0;
            period_s = '0;
            gate_s   = 1'b0;
        end else if (start) begin
            // Retrigger from any state; the current note is cut and the
            // LOAD cycle behaves like a note gap.
            state_s  = ST_LOAD;
            addr_s   = '0;
            cnt_s    = 7'd0;
            gate_s   = GAP_EN ? 1'b0 : gate_r;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    state_s = ST_IDLE;
                end
                ST_LOAD: begin
                    if (pitch_s == PITCH_END) begin
                        if (loop) begin
                            // END at step 0 with loop set spins in LOAD
                            // without ever strobing a note.
                            addr_s  = '0;
                            state_s = ST_LOAD;
                        end else begin
                            state_s  = ST_DONE;
                            period_s = '0;
                            gate_s   = 1'b0;
                        end
                    end else begin
                        period_s = PERIOD_W'(pitch_half_period(pitch_s));
                        gate_s   = pitch_is_tone(pitch_s);
                        cnt_s    = note_len_s;
                        strobe_s = 1'b1;
                        state_s  = ST_PLAY;
                    end
                end
                ST_PLAY: begin
                    if (frame_tick) begin
                        if (cnt_r <= 7'd1) begin
                            // Last frame of the note: the following LOAD cycle
                            // keeps the old period with the gate in gap state.
                            cnt_s  = 7'd0;
                            gate_s = GAP_EN ? 1'b0 : gate_r;
                            if (addr_r == LAST_ADDR) begin
                                if (loop) begin
                                    addr_s  = '0;
                                    state_s = ST_LOAD;
                                end else begin
                                    state_s  = ST_DONE;
                                    period_s = '0;
                                    gate_s   = 1'b0;
                                end
                            end else begin
                                addr_s  = addr_r + AW'(1);
                                state_s = ST_LOAD;
                            end
                        end else if (GAP_EN && (cnt_r == GAP_TRIP)) begin
                            cnt_s  = cnt_r - 7'd1;
                            gate_s = 1'b0;
                        end else begin
                            cnt_s  = cnt_r - 7'd1;
                        end
                    end else begin
                        cnt_s = cnt_r;
                    end
                end
                ST_DONE: begin
                    state_s = ST_DONE;
                end
                default: begin
                    state_s  = ST_IDLE;
                    addr_s   = '0;
                    cnt_s    = 7'd0;
                    period_s = '0;
                    gate_s   = 1'b0;
                end
            endcase
        end

        busy_s = (state_s == ST_LOAD) || (state_s == ST_PLAY);
        done_s = (state_s == ST_DONE);
    end

    // State, counter and output registers with asynchronous clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r  <= ST_IDLE;
            addr_r   <= '0;
            cnt_r    <= 7'd0;
            period_r <= '0;
            gate_r   <= 1'b0;
            strobe_r <= 1'b0;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
        end else begin
            state_r  <= state_s;
            addr_r   <= addr_s;
            cnt_r    <= cnt_s;
            period_r <= period_s;
            gate_r   <= gate_s;
            strobe_r <= strobe_s;
            busy_r   <= busy_s;
            done_r   <= done_s;
        end
    end

    assign rom_addr    = addr_r;
    assign note_period = period_r;
    assign note_gate   = gate_r;
    assign note_strobe = strobe_r;
    assign busy        = busy_r;
    assign done        = done_r;

endmodule

// File: tb/tb_music_note_sequencer.sv
`timescale 1ns/1ps
module tb_music_note_sequencer;

    localparam int SONG_LEN   = 32;
    localparam int GAP_FRAMES = 2;
    localparam int PERIOD_W   = 16;
    localparam int AW         = 5;

    logic                clk        = 1'b0;
    logic                rst_n      = 1'b1;
    logic                frame_tick = 1'b0;
    logic                start      = 1'b0;
    logic                stop       = 1'b0;
    logic                loop       = 1'b0;
    logic [1:0]          tempo      = 2'b10;
    logic [AW-1:0]       rom_addr;
    logic [6:0]          rom_data;
    logic [PERIOD_W-1:0] note_period;
    logic                note_gate;
    logic                note_strobe;
    logic                busy;
    logic                done;

    logic [6:0] rom_mem [SONG_LEN];
    assign rom_data = rom_mem[rom_addr];

    always #5 clk = ~clk;

    music_note_sequencer #(
        .SONG_LEN   (SONG_LEN),
        .GAP_FRAMES (GAP_FRAMES),
        .PERIOD_W   (PERIOD_W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .frame_tick  (frame_tick),
        .start       (start),
        .stop        (stop),
        .loop        (loop),
        .tempo       (tempo),
        .rom_addr    (rom_addr),
        .rom_data    (rom_data),
        .note_period (note_period),
        .note_gate   (note_gate),
        .note_strobe (note_strobe),
        .busy        (busy),
        .done        (done)
    );

    typedef struct {
        logic [PERIOD_W-1:0] period;
        logic                gate;
    } exp_t;

    typedef struct {
        logic [3:0]          pitch;
        logic [2:0]          dur;
        logic [1:0]          tempo;
        logic                til;     // frame_tick also high during LOAD
        logic [PERIOD_W-1:0] period;
        logic                gate;
    } vec_t;

    exp_t exp_q[$];
    exp_t mon_e;
    vec_t vecs[10];
    int   n_checks  = 0;
    int   n_pass    = 0;
    int   n_strobes = 0;
    logic strobe_prev = 1'b0;
    localparam logic [6:0] END_WORD = 7'h78;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, req);
    endtask

    function automatic int u_of(input logic [1:0] t);
`ifdef MUSIC_SEQ_TEMPO_EN
        case (t)
            2'b00:   return 4;
            2'b01:   return 6;
            2'b10:   return 8;
            default: return 12;
        endcase
`else
        return 8;
`endif
    endfunction

    function automatic logic [PERIOD_W-1:0] ref_period(input int p);
        case (p)
            1: return 16'd48113;   2: return 16'd45412;   3: return 16'd42864;
            4: return 16'd40458;   5: return 16'd38187;   6: return 16'd36044;
            7: return 16'd34021;   8: return 16'd32111;   9: return 16'd30309;
            10: return 16'd28608; 11: return 16'd27002;  12: return 16'd25487;
            default: return 16'd0;
        endcase
    endfunction

    // Scoreboard: every strobe pops the next expected note
    always @(negedge clk) begin
        if (rst_n && note_strobe) begin
            n_strobes++;
            check("strobe_width", strobe_prev, 0);
            check("strobe_expected", 32'(exp_q.size() != 0), 1);
            if (exp_q.size() != 0) begin
                mon_e = exp_q.pop_front();
                check("sb_period", note_period, mon_e.period);
                check("sb_gate", note_gate, mon_e.gate);
            end
        end
        strobe_prev = note_strobe;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic tick();
        step();
        frame_tick = 1'b1;
        step();
        frame_tick = 1'b0;
    endtask

    task automatic pulse_start(input logic til);
        step();
        start = 1'b1;
        step();
        start      = 1'b0;
        frame_tick = til;
        check("load_busy", busy, 1);
        check("load_no_strobe", note_strobe, 0);
    endtask

    // Tick through one note; measure when the gate falls and when it ends
    task automatic play_note(input string tag, input int len, input logic gated,
                             input logic [PERIOD_W-1:0] per, input int chg_n,
                             input logic [1:0] chg_t);
        logic [AW-1:0] a0;
        int fall_n;
        int end_n;
        a0     = rom_addr;
        fall_n = -1;
        end_n  = -1;
        for (int n = 1; n <= 200 && end_n < 0; n++) begin
            tick();
            if (n == chg_n) tempo = chg_t;
            if (fall_n < 0 && !note_gate) fall_n = n;
            if (rom_addr != a0 || done) end_n = n;
        end
        check({tag, "_len"}, end_n, len);
        if (gated) check({tag, "_gate_fall"}, fall_n, len - GAP_FRAMES);
        check({tag, "_gap_gate"}, note_gate, 0);
        if (!done) check({tag, "_gap_period"}, note_period, per);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int s;
        vecs[0] = vec_t'{4'd10, 3'd3, 2'b10, 1'b0, 16'd28608, 1'b1};
        vecs[1] = vec_t'{4'd0,  3'd0, 2'b10, 1'b1, 16'd0,     1'b0};
        vecs[2] = vec_t'{4'd1,  3'd0, 2'b11, 1'b0, 16'd48113, 1'b1};
        vecs[3] = vec_t'{4'd12, 3'd1, 2'b00, 1'b1, 16'd25487, 1'b1};
        vecs[4] = vec_t'{4'd13, 3'd0, 2'b01, 1'b0, 16'd0,     1'b0};
        vecs[5] = vec_t'{4'd14, 3'd2, 2'b11, 1'b0, 16'd0,     1'b0};
        vecs[6] = vec_t'{4'd5,  3'd7, 2'b11, 1'b1, 16'd38187, 1'b1};
        vecs[7] = vec_t'{4'd2,  3'd0, 2'b01, 1'b0, 16'd45412, 1'b1};
        vecs[8] = vec_t'{4'd3,  3'd4, 2'b00, 1'b0, 16'd42864, 1'b1};
        vecs[9] = vec_t'{4'd8,  3'd2, 2'b10, 1'b0, 16'd32111, 1'b1};
        for (int i = 0; i < SONG_LEN; i++) rom_mem[i] = 7'd0;

        // Reset state
        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_addr", rom_addr, 0);
        check("rst_period", note_period, 0);
        check("rst_gate", note_gate, 0);
        check("rst_strobe", note_strobe, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        #3 rst_n = 1'b1;
        step();
        check("idle_busy", busy, 0);

        // Single-note vectors, each followed by END with loop=0
        for (int v = 0; v < 10; v++) begin
            int len;
            len = (int'(vecs[v].dur) + 1) * u_of(vecs[v].tempo);
            rom_mem[0] = {vecs[v].pitch, vecs[v].dur};
            rom_mem[1] = END_WORD;
            loop  = 1'b0;
            tempo = vecs[v].tempo;
            exp_q.push_back(exp_t'{vecs[v].period, vecs[v].gate});
            pulse_start(vecs[v].til);
            play_note("vec", len, vecs[v].gate, vecs[v].period, 0, 2'b00);
            step();
            step();
            check("vec_done", done, 1);
            check("vec_busy", busy, 0);
            check("vec_done_period", note_period, 0);
            check("vec_done_gate", note_gate, 0);
        end

        // Tempo changed mid-note has no effect on the current note
        rom_mem[0] = {4'd1, 3'd0};
        rom_mem[1] = END_WORD;
        tempo = 2'b11;
        exp_q.push_back(exp_t'{16'd48113, 1'b1});
        pulse_start(1'b0);
        play_note("tempo_chg", u_of(2'b11), 1'b1, 16'd48113, 3, 2'b00);
        step();
        step();
        check("tempo_chg_done", done, 1);

        // Looping song: note, rest, END -> back to step 0
        rom_mem[0] = {4'd10, 3'd3};
        rom_mem[1] = {4'd0, 3'd0};
        rom_mem[2] = END_WORD;
        loop  = 1'b1;
        tempo = 2'b10;
        exp_q.push_back(exp_t'{16'd28608, 1'b1});
        exp_q.push_back(exp_t'{16'd0, 1'b0});
        exp_q.push_back(exp_t'{16'd28608, 1'b1});
        pulse_start(1'b0);
        play_note("song0", 4 * u_of(2'b10), 1'b1, 16'd28608, 0, 2'b00);
        check("song_addr1", rom_addr, 1);
        play_note("song1", u_of(2'b10), 1'b0, 16'd0, 0, 2'b00);
        step();
        check("loop_addr0", rom_addr, 0);
        check("loop_load_busy", busy, 1);
        check("loop_load_strobe", note_strobe, 0);
        step();
        check("loop_strobe", note_strobe, 1);
        check("loop_period", note_period, 28608);
        tick();
        tick();
        // stop and start together mid-note: stop wins
        step();
        stop  = 1'b1;
        start = 1'b1;
        step();
        stop  = 1'b0;
        start = 1'b0;
        check("stopstart_busy", busy, 0);
        check("stopstart_period", note_period, 0);
        check("stopstart_gate", note_gate, 0);
        check("stopstart_addr", rom_addr, 0);
        check("stopstart_done", done, 0);
        s = n_strobes;
        tick();
        tick();
        check("idle_no_strobe", n_strobes, s);
        check("idle_still_busy", busy, 0);

        // END at step 0 with loop: spins without strobing
        rom_mem[0] = END_WORD;
        loop = 1'b1;
        s = n_strobes;
        pulse_start(1'b0);
        repeat (6) step();
        check("endloop_busy", busy, 1);
        check("endloop_done", done, 0);
        check("endloop_addr", rom_addr, 0);
        check("endloop_strobes", n_strobes, s);
        stop = 1'b1;
        step();
        stop = 1'b0;
        check("endloop_stop_busy", busy, 0);

        // Asynchronous reset mid-note
        rom_mem[0] = {4'd10, 3'd3};
        rom_mem[1] = END_WORD;
        loop = 1'b0;
        exp_q.push_back(exp_t'{16'd28608, 1'b1});
        pulse_start(1'b0);
        tick();
        tick();
        tick();
        check("pre_rst_period", note_period, 28608);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("arst_period", note_period, 0);
        check("arst_gate", note_gate, 0);
        check("arst_busy", busy, 0);
        #2 rst_n = 1'b1;
        step();
        check("arst_idle_busy", busy, 0);
        check("arst_idle_period", note_period, 0);

        // Full ROM without END, loop=0: DONE after step 31
        for (int i = 0; i < SONG_LEN; i++) rom_mem[i] = {4'(1 + (i % 12)), 3'd0};
        tempo = 2'b00;
        for (int i = 0; i < SONG_LEN; i++) exp_q.push_back(exp_t'{ref_period(1 + (i % 12)), 1'b1});
        pulse_start(1'b0);
        for (int i = 0; i < SONG_LEN; i++) begin
            check("full_addr", rom_addr, i);
            play_note("full", u_of(2'b00), 1'b1, ref_period(1 + (i % 12)), 0, 2'b00);
        end
        check("full_done", done, 1);
        check("full_busy", busy, 0);
        check("full_last_addr", rom_addr, SONG_LEN - 1);
        check("full_period", note_period, 0);
        step();
        stop = 1'b1;
        step();
        stop = 1'b0;
        check("done_stop", done, 0);
        check("queue_drained", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
